// File: rtl/fir_mac_seq.sv
// fir_mac_seq: time-multiplexed FIR with one MAC over a circular sample buffer,
// runtime-writable coefficients, round-half-up scaling and output saturation.
module fir_mac_seq #(
    parameter int WD_IN   = 24,
    parameter int WD_OUT  = 24,
    parameter int WD_COEF = 18,
    parameter int TAPS    = 32,
    parameter int SHIFT   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WD_IN-1:0]         data_in,
    output logic                     out_valid,
    output logic [WD_OUT-1:0]        data_out,
    output logic                     sat,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [WD_COEF-1:0]       coef_data
);
    localparam int AW     = $clog2(TAPS);
    localparam int WD_ACC = WD_IN + WD_COEF + AW;
    localparam logic signed [WD_ACC:0] O_MAX = {{(WD_ACC+2-WD_OUT){1'b0}}, {(WD_OUT-1){1'b1}}};
    localparam logic signed [WD_ACC:0] O_MIN = ~O_MAX;
    localparam logic signed [WD_ACC:0] HALF  = (WD_ACC+1)'(1) << (SHIFT-1);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                      state, nxt;
    logic signed [WD_IN-1:0]     smp  [TAPS];
    logic signed [WD_COEF-1:0]   coef [TAPS];
    logic [AW-1:0]               wr_ptr, newest, k, idx;
    logic [AW:0]                 diff;
    logic signed [WD_ACC-1:0]    acc;
    logic signed [WD_IN+WD_COEF-1:0] prod;
    logic signed [WD_ACC:0]      sum, r;
    logic                        ovf_hi, ovf_lo, accept, last;

    assign in_ready = state == IDLE;
    assign accept   = in_valid && in_ready;
    assign last     = k == AW'(TAPS-1);

    // Tap k reads the sample k steps older than the newest, wrapping around the buffer.
    always_comb begin
        diff   = {1'b0, newest} - {1'b0, k};
        idx    = diff[AW] ? AW'(diff + (AW+1)'(TAPS)) : diff[AW-1:0];
        prod   = smp[idx] * coef[k];
        sum    = {acc[WD_ACC-1], acc} + HALF;
        r      = sum >>> SHIFT;
        ovf_hi = r > O_MAX;
        ovf_lo = r < O_MIN;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = accept ? MAC : IDLE;
            MAC:     nxt = last ? OUT : MAC;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                smp[i]  <= '0;
                coef[i] <= '0;
            end
            wr_ptr    <= '0;
            newest    <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            sat       <= 1'b0;
        end else begin
            state     <= nxt;
            out_valid <= state == OUT;
            if (coef_we && state == IDLE)
                coef[coef_addr] <= coef_data;
            if (accept) begin
                smp[wr_ptr] <= data_in;
                newest      <= wr_ptr;
                wr_ptr      <= wr_ptr == AW'(TAPS-1) ? '0 : wr_ptr + 1'b1;
                acc         <= '0;
                k           <= '0;
            end
            if (state == MAC) begin
                acc <= acc + {{(WD_ACC-WD_IN-WD_COEF){prod[WD_IN+WD_COEF-1]}}, prod};
                k   <= last ? '0 : k + 1'b1;
            end
            if (state == OUT) begin
                data_out <= ovf_hi ? O_MAX[WD_OUT-1:0] : ovf_lo ? O_MIN[WD_OUT-1:0] : r[WD_OUT-1:0];
                sat      <= ovf_hi || ovf_lo;
            end
        end
    end
endmodule
